fetch_ctrl: RTL

Sequencing controller for the 8-bit-PC fetch stage. It merges decode-side hazard stalls, branch/jump redirects and halt/resume requests into the fetch stage's `stall`, `flush` and `branch_target` controls. A redirect that arrives while the pipe is stalled or halted is held as a pending redirect and replayed later, so it is never lost. It sits between the hazard/branch units and the fetch stage, one instance per core.

---
 rtl/fetch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencing controller.
// Merges decode hazard stalls, branch/jump redirects and halt/resume into the
// fetch stage's stall/flush/branch_target. A redirect that arrives while the
// pipe is stalled or halted is held pending and replayed, so none is lost.
// Optional feature: define FETCH_CTRL_PERF_EN to build the stall-cycle and
// redirect performance counters; otherwise both counter ports read zero.
module fetch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1  // flush cycles per redirect, 1..7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dec_stall,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  input  logic        jump,
  input  logic [7:0]  jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        fetch_stall,
  output logic        fetch_flush,
  output logic [7:0]  fetch_target,
  output logic        halted,
  output logic        pend_valid,
  output logic [15:0] perf_stall_cycles,
  output logic [15:0] perf_redirects
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_REDIRECT,
    S_PEND,
    S_HALTED
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tgt_q, tgt_d;
  logic        pend_q, pend_d;

  logic        redir;
  logic [7:0]  redir_tgt;

  assign redir     = br_taken | jump;
  assign redir_tgt = jump ? jump_target : br_target;  // jump wins a collision

  // State, flush counter, latched target and pending flag.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: latch every redirect outside BOOT, then sequence.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;

    // Latest redirect always wins the latched target.
    if (redir && state_q != S_BOOT) begin
      tgt_d  = redir_tgt;
      pend_d = 1'b1;
    end

    unique case (state_q)
      S_BOOT: state_d = S_RUN;

      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (redir && !dec_stall) begin
          state_d = S_REDIRECT;
          cnt_d   = FLUSH_LOAD;
        end else if (redir) begin
          state_d = S_PEND;
        end
      end

      S_REDIRECT: begin
        if (halt_req) begin
          state_d = S_HALTED;               // target stays pending
        end else if (redir) begin
          cnt_d   = FLUSH_LOAD;             // restart the flush window
        end else if (!dec_stall) begin
          if (cnt_q <= 3'd1) begin          // last flush cycle, never wraps
            cnt_d   = '0;
            state_d = S_RUN;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      S_PEND: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (!dec_stall) begin
          state_d = S_REDIRECT;
          cnt_d   = FLUSH_LOAD;
        end
      end

      S_HALTED: begin
        if (resume && !halt_req) begin
          if (pend_d) begin
            state_d = S_REDIRECT;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // Outputs: flush/halted decode registered state; stall adds decode's request.
  assign fetch_stall  = dec_stall | (state_q == S_BOOT) | (state_q == S_PEND) |
                        (state_q == S_HALTED);
  assign fetch_flush  = (state_q == S_REDIRECT);
  assign halted       = (state_q == S_HALTED);
  assign fetch_target = tgt_q;
  assign pend_valid   = pend_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] redir_cnt_q;
  logic        enter_redirect;

  assign enter_redirect = (state_d == S_REDIRECT) && (state_q != S_REDIRECT);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (fetch_stall && state_q != S_BOOT && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (enter_redirect && redir_cnt_q != 16'hFFFF)
        redir_cnt_q <= redir_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_redirects    = redir_cnt_q;
`else
  assign perf_stall_cycles = 16'h0000;
  assign perf_redirects    = 16'h0000;
`endif

endmodule
